// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: pixel-rate divider, h/v counters and
// registered sync/blank decodes that always describe the pixel at (hPixel, vLine).
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       CLK,
  input  logic       RSTn,
  output logic [9:0] hPixel,
  output logic [9:0] vLine,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       BLANK_N,
  output logic       VGA_CLK,
  output logic       pixTick,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_ACT    = 10'(V_VISIBLE);
  // Sync window bounds are 11 bits so an end at exactly 1024 still compares correctly.
  localparam logic [10:0]      HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]      HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]      VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]      VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             tick_now;
  logic             frame_next;

  // Next-state: divider, counters, and the frame-wrap strobe for the coming tick cycle
  always_comb begin
    tick_now = (div_cnt == DIV_LAST);
    div_next = tick_now ? '0 : div_cnt + 1'b1;
    h_next   = hPixel;
    v_next   = vLine;
    if (tick_now) begin
      if (hPixel == H_LAST) begin
        h_next = '0;
        v_next = (vLine == V_LAST) ? '0 : vLine + 10'd1;
      end else begin
        h_next = hPixel + 10'd1;
      end
    end
    // Counters never move on the edge entering a tick cycle, so the current
    // position is the one the coming tick will wrap from.
    frame_next = (div_next == DIV_LAST) && (hPixel == H_LAST) && (vLine == V_LAST);
  end

  // Output registers: decodes come from the next counter values so they move with them
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      div_cnt    <= '0;
      hPixel     <= '0;
      vLine      <= '0;
      HSYNC      <= 1'b1;
      VSYNC      <= 1'b1;
      BLANK_N    <= 1'b1;
      VGA_CLK    <= 1'b0;
      pixTick    <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      hPixel     <= h_next;
      vLine      <= v_next;
      HSYNC      <= !(({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END));
      VSYNC      <= !(({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END));
      BLANK_N    <= (h_next < H_ACT) && (v_next < V_ACT);
      VGA_CLK    <= (div_next >= DIV_HALF);
      pixTick    <= (div_next == DIV_LAST);
      frameStart <= frame_next;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (defaults, a tiny raster, CLK_DIV=4 variant)
// checked cycle by cycle against an elapsed-time raster model plus directed sequences.
module tb_vga_timing;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_b, rst_c;
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic hs_a, vs_a, bn_a, vc_a, tk_a, fs_a;
  logic hs_b, vs_b, bn_b, vc_b, tk_b, fs_b;
  logic hs_c, vs_c, bn_c, vc_c, tk_c, fs_c;

  vga_timing dut_a (
    .CLK(CLK), .RSTn(rst_a), .hPixel(h_a), .vLine(v_a), .HSYNC(hs_a), .VSYNC(vs_a),
    .BLANK_N(bn_a), .VGA_CLK(vc_a), .pixTick(tk_a), .frameStart(fs_a)
  );

  vga_timing #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .CLK(CLK), .RSTn(rst_b), .hPixel(h_b), .vLine(v_b), .HSYNC(hs_b), .VSYNC(vs_b),
    .BLANK_N(bn_b), .VGA_CLK(vc_b), .pixTick(tk_b), .frameStart(fs_b)
  );

  vga_timing #(.CLK_DIV(4), .H_BP(8)) dut_c (
    .CLK(CLK), .RSTn(rst_c), .hPixel(h_c), .vLine(v_c), .HSYNC(hs_c), .VSYNC(vs_c),
    .BLANK_N(bn_c), .VGA_CLK(vc_c), .pixTick(tk_c), .frameStart(fs_c)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       vc;
    logic       tk;
    logic       fs;
  } out_t;

  out_t o_a, o_b, o_c;
  assign o_a = {h_a, v_a, hs_a, vs_a, bn_a, vc_a, tk_a, fs_a};
  assign o_b = {h_b, v_b, hs_b, vs_b, bn_b, vc_b, tk_b, fs_b};
  assign o_c = {h_c, v_c, hs_c, vs_c, bn_c, vc_c, tk_c, fs_c};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: the raster position is a pure function of cycles elapsed since reset.
  function automatic out_t model(input int t, input int cd, input int hv, input int hfp,
                                 input int hsw, input int hbp, input int vv, input int vfp,
                                 input int vsw, input int vbp);
    out_t m;
    int ht, vt, p, ph, h, v;
    ht   = hv + hfp + hsw + hbp;
    vt   = vv + vfp + vsw + vbp;
    p    = t / cd;
    ph   = t % cd;
    h    = p % ht;
    v    = (p / ht) % vt;
    m.h  = 10'(h);
    m.v  = 10'(v);
    m.hs = !((h >= hv + hfp) && (h < hv + hfp + hsw));
    m.vs = !((v >= vv + vfp) && (v < vv + vfp + vsw));
    m.bn = (h < hv) && (v < vv);
    m.vc = (ph >= cd / 2);
    m.tk = (ph == cd - 1);
    m.fs = m.tk && (h == ht - 1) && (v == vt - 1);
    return m;
  endfunction

  int t_a = 0, t_b = 0, t_c = 0;
  always @(posedge CLK) begin
    t_a <= rst_a ? t_a + 1 : 0;
    t_b <= rst_b ? t_b + 1 : 0;
    t_c <= rst_c ? t_c + 1 : 0;
  end

  logic mon_en = 1'b0;
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("model_a", 32'(o_a), 32'(model(t_a, 2, 640, 16, 96, 48, 480, 10, 2, 33)));
      chk("model_b", 32'(o_b), 32'(model(t_b, 2, 8, 2, 3, 2, 6, 2, 2, 3)));
      chk("model_c", 32'(o_c), 32'(model(t_c, 4, 640, 16, 96, 8, 480, 10, 2, 33)));
    end
  end

  typedef struct {
    int rst;
    int n;
    int h;
    int v;
    int hs;
    int vs;
    int bn;
    int tk;
    int vc;
  } vec_t;

  vec_t tbl[19];
  localparam out_t RESET_OUT = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  int first, second, nfs, bad_vs, bad_bn, vs_low, found;
  int w1, w2, maxh, last_tick, bad_tick, ntick, prev_h;

  initial begin
    //         rst  n     h    v  hs vs bn tk vc
    tbl[0]  = '{0,   5,    0,   0, 1, 1, 1, 0, 0};
    tbl[1]  = '{1,   1,    0,   0, 1, 1, 1, 1, 1};
    tbl[2]  = '{1,   1,    1,   0, 1, 1, 1, 0, 0};
    tbl[3]  = '{1,   1,    1,   0, 1, 1, 1, 1, 1};
    tbl[4]  = '{1,   36,   19,  0, 1, 1, 1, 1, 1};
    tbl[5]  = '{1,   1,    20,  0, 1, 1, 1, 0, 0};
    tbl[6]  = '{1,   1238, 639, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{1,   1,    639, 0, 1, 1, 1, 1, 1};
    tbl[8]  = '{1,   1,    640, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{1,   31,   655, 0, 1, 1, 0, 1, 1};
    tbl[10] = '{1,   1,    656, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1,   191,  751, 0, 0, 1, 0, 1, 1};
    tbl[12] = '{1,   1,    752, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{1,   95,   799, 0, 1, 1, 0, 1, 1};
    tbl[14] = '{1,   1,    0,   1, 1, 1, 1, 0, 0};
    tbl[15] = '{1,   20,   10,  1, 1, 1, 1, 0, 0};
    tbl[16] = '{0,   1,    0,   0, 1, 1, 1, 0, 0};
    tbl[17] = '{1,   1,    0,   0, 1, 1, 1, 1, 1};
    tbl[18] = '{1,   1,    1,   0, 1, 1, 1, 0, 0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (2) @(negedge CLK);
    mon_en = 1'b1;

    // Default raster: reset, release, pixel cadence, horizontal decode, mid-line reset
    for (int i = 0; i < 19; i++) begin
      rst_a = (tbl[i].rst != 0);
      repeat (tbl[i].n) @(negedge CLK);
      chk($sformatf("vec%0d_h", i),  32'(h_a),  tbl[i].h);
      chk($sformatf("vec%0d_v", i),  32'(v_a),  tbl[i].v);
      chk($sformatf("vec%0d_hs", i), 32'(hs_a), tbl[i].hs);
      chk($sformatf("vec%0d_vs", i), 32'(vs_a), tbl[i].vs);
      chk($sformatf("vec%0d_bn", i), 32'(bn_a), tbl[i].bn);
      chk($sformatf("vec%0d_tk", i), 32'(tk_a), tbl[i].tk);
      chk($sformatf("vec%0d_vc", i), 32'(vc_a), tbl[i].vc);
    end

    // Tiny raster (15x13 pixels, frame = 390 CLK): vertical decode and frame strobe
    rst_b  = 1'b1;
    first  = -1;
    second = -1;
    nfs    = 0;
    bad_vs = 0;
    bad_bn = 0;
    vs_low = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge CLK);
      if (fs_b) begin
        nfs++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
        chk("b_fs_pos_h", 32'(h_b), 14);
        chk("b_fs_pos_v", 32'(v_b), 12);
      end
      if (vs_b !== !((v_b >= 10'd8) && (v_b <= 10'd9))) bad_vs++;
      if ((v_b >= 10'd6) && (bn_b !== 1'b0)) bad_bn++;
      if (vs_b === 1'b0) vs_low++;
    end
    chk("b_first_fs", first, 389);
    chk("b_fs_period", second - first, 390);
    chk("b_fs_count", nfs, 2);
    chk("b_vsync_window", bad_vs, 0);
    chk("b_blank_lines", bad_bn, 0);
    chk("b_vsync_low_cycles", vs_low, 120);

    // Mid-frame reset while both syncs are active
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge CLK);
      if ((h_b == 10'd11) && (v_b == 10'd8)) found = 1;
    end
    chk("b_reach_midframe", found, 1);
    if (found != 0) begin
      chk("b_mid_hsync", 32'(hs_b), 0);
      chk("b_mid_vsync", 32'(vs_b), 0);
      rst_b = 1'b0;
      @(negedge CLK);
      chk("b_mid_reset_vals", 32'(o_b), 32'(RESET_OUT));
      rst_b = 1'b1;
      @(negedge CLK);
      chk("b_restart_tick", 32'(tk_b), 1);
      chk("b_restart_h0", 32'(h_b), 0);
      @(negedge CLK);
      chk("b_restart_h1", 32'(h_b), 1);
    end

    // CLK_DIV=4, H_TOTAL=760: tick spacing and line period
    rst_c     = 1'b1;
    w1        = -1;
    w2        = -1;
    maxh      = 0;
    last_tick = -1;
    bad_tick  = 0;
    ntick     = 0;
    prev_h    = 0;
    for (int k = 1; k <= 7000; k++) begin
      @(negedge CLK);
      if (tk_c) begin
        ntick++;
        if ((last_tick >= 0) && (k - last_tick != 4)) bad_tick++;
        last_tick = k;
      end
      if (int'(h_c) > maxh) maxh = int'(h_c);
      if ((prev_h == 759) && (h_c == 10'd0)) begin
        if (w1 < 0) begin
          w1 = k;
          chk("c_vline_after_wrap", 32'(v_c), 1);
        end else begin
          w2 = k;
        end
      end
      prev_h = int'(h_c);
      if (w2 >= 0) break;
    end
    chk("c_tick_spacing", bad_tick, 0);
    chk("c_first_tick", (ntick > 0) ? 32'd1 : 32'd0, 1);
    chk("c_max_hpixel", maxh, 759);
    chk("c_first_wrap", w1, 3040);
    chk("c_line_period", w2 - w1, 3040);

    // Random resets on all instances; the model monitor checks every cycle
    for (int k = 0; k < 6000; k++) begin
      @(negedge CLK);
      rst_a = ($urandom_range(0, 299) != 0);
      rst_b = ($urandom_range(0, 699) != 0);
      rst_c = ($urandom_range(0, 199) != 0);
    end

    @(negedge CLK);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480 @ 60 Hz VGA output path. It divides the system clock down to the pixel rate and produces the horizontal pixel and vertical line counters consumed by the downstream pattern generator. It also produces the active-low sync pulses, the blanking flag and the DAC clock that drive the video DAC. All outputs are registered and mutually consistent: on any cycle, HSYNC, VSYNC and BLANK_N describe the pixel at the current hPixel/vLine.

## Interface
- CLK_DIV, 2: system clocks per pixel. Must be even and ≥2.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- Derived values:
  - H_TOTAL = sum of the H_* parameters (800). Must be ≤1024.
  - V_TOTAL = sum of the V_* parameters (525). Must be ≤1024.

Ports:
- CLK  in  1: system clock (50 MHz). The only clock.
- RSTn  in  1: reset. Synchronous, active-low.
- hPixel  out  10: current pixel column, 0..H_TOTAL-1.
- vLine  out  10: current line, 0..V_TOTAL-1.
- HSYNC  out  1: horizontal sync, active low.
- VSYNC  out  1: vertical sync, active low.
- BLANK_N  out  1: high when the current pixel is inside the visible area.
- VGA_CLK  out  1: pixel clock to the DAC.
- pixTick  out  1: one-CLK strobe, high on the last CLK cycle of each pixel period.
- frameStart  out  1: one-CLK strobe on the pixTick that wraps the counters to (0,0).

## Operation
- Divider:
  - divCnt counts 0..CLK_DIV-1, then wraps to 0.
  - pixTick is high exactly when divCnt == CLK_DIV-1.
- VGA_CLK:
  - Registered.
  - Low while divCnt < CLK_DIV/2, high otherwise.
  - Its rising edge falls mid-pixel, so the DAC samples stable data.
- Horizontal counter: on pixTick, hPixel increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - vLine increments only on a pixTick where hPixel == H_TOTAL-1.
  - At the wrap of hPixel from H_TOTAL-1 with vLine == V_TOTAL-1, both counters go to 0.
- Counters hold their value between ticks.
- Decodes are registered. On each pixTick they are computed from the next counter values, so they change on the same edge as the counters.
  - HSYNC = 0 iff H_VISIBLE+H_FP ≤ hPixel < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751 at the defaults.
  - VSYNC = 0 iff V_VISIBLE+V_FP ≤ vLine < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491 at the defaults.
  - BLANK_N = 1 iff hPixel < H_VISIBLE and vLine < V_VISIBLE.
- frameStart is high for the one CLK cycle of the tick whose next counter state is (0,0).
- Reset:
  - Synchronous, active-low.
  - Takes priority over all counting, including mid-frame and mid-pixel.
- Reset values:
  - divCnt = 0, hPixel = 0, vLine = 0.
  - HSYNC = 1, VSYNC = 1, BLANK_N = 1 (pixel (0,0) is visible).
  - VGA_CLK = 0, pixTick = 0, frameStart = 0.
- Because of the reset values, the first pixel period after reset release is pixel (0,0). It lasts CLK_DIV cycles.

## Timing
- The first pixTick occurs CLK_DIV cycles after the first CLK edge with RSTn = 1. It is the CLK_DIV-th cycle, where divCnt == CLK_DIV-1.
- Each counter value and its decodes are stable for exactly CLK_DIV CLK cycles.
- Line period is H_TOTAL·CLK_DIV CLK cycles (1600 at the defaults).
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV CLK cycles (840 000 at the defaults).
- Pulse widths at the defaults:
  - HSYNC low for 96 pixel periods (192 CLK).
  - VSYNC low for 2 full lines (3200 CLK).
- The downstream pattern generator is combinational, so its RGB matches the current hPixel/vLine with zero added latency.
- frameStart and pixTick are single-cycle pulses, never stretched.
- Reset asserted mid-frame: on the next CLK edge all outputs take their reset values.

## Test plan
- Reset/release: hold RSTn = 0 for 5 cycles, then release.
  - During and just after reset: hPixel = 0, vLine = 0, HSYNC = 1, VSYNC = 1, BLANK_N = 1, pixTick = 0.
  - First pixTick in cycle 2 after release. hPixel reads 1 from cycle 3.
- Pixel cadence: run 20 pixels.
  - pixTick high 1 cycle in every 2.
  - VGA_CLK period 2 CLK, rising while divCnt = 1.
  - hPixel steps 0..19.
- Horizontal decode:
  - BLANK_N falls when hPixel becomes 640.
  - HSYNC falls when hPixel becomes 656 and rises when it becomes 752.
  - hPixel goes 799→0 while vLine goes 0→1 on the same edge.
- Vertical decode over a full frame:
  - VSYNC low exactly while vLine ∈ {490, 491}.
  - BLANK_N = 0 for all of lines 480..524.
  - frameStart pulses once at the (799,524)→(0,0) transition.
  - Next frameStart arrives exactly 840 000 CLK later.
- Mid-frame reset: assert RSTn = 0 for 1 cycle at hPixel = 700, vLine = 490 (HSYNC = 0, VSYNC = 0).
  - Next cycle: all reset values.
  - Counting restarts from (0,0) with the first tick 2 cycles after release.
- Parameter override (CLK_DIV = 4, H_TOTAL reduced via H_BP = 8): pixTick every 4 cycles, hPixel wraps at 759, line period 3040 CLK.
